// File: rtl/width_128to24.sv
// width_128to24: unpacks 128-bit words into 24-bit samples, MSB-first, via a 151-bit residue buffer.
// Optional WIDTH_128TO24_FLUSH_EN adds a synchronous flush input that drops any residue.
module width_128to24 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic [127:0] data_in,
    output logic         ready_in,
    output logic         valid_out,
    output logic [23:0]  data_out,
    input  logic         ready_out
`ifdef WIDTH_128TO24_FLUSH_EN
    ,
    input  logic         flush
`endif
);

    logic [150:0] buf_q;
    logic [150:0] buf_d;
    logic [150:0] buf_shifted;
    logic [150:0] word_placed;
    logic [7:0]   cnt_q;
    logic [7:0]   cnt_d;
    logic [7:0]   cnt_popped;
    logic         flush_active;
    logic         has_sample;
    logic         fire_in;
    logic         fire_out;

`ifdef WIDTH_128TO24_FLUSH_EN
    assign flush_active = flush;
`else
    assign flush_active = 1'b0;
`endif

    assign has_sample = (cnt_q >= 8'd24);
    assign valid_out  = has_sample && !flush_active;
    assign data_out   = buf_q[150:127];
    assign fire_out   = valid_out && ready_out;

    // A word is only accepted if it fits once the current sample (if any) leaves.
    assign ready_in = !flush_active &&
                      ((cnt_q < 8'd24) || ((cnt_q < 8'd48) && fire_out));
    assign fire_in  = valid_in && ready_in;

    always_comb begin
        cnt_popped  = fire_out ? (cnt_q - 8'd24) : cnt_q;
        buf_shifted = fire_out ? {buf_q[126:0], 24'd0} : buf_q;
        // Land the new word directly below the surviving residue bits.
        word_placed = {data_in, 23'd0} >> cnt_popped;
        buf_d       = buf_shifted;
        cnt_d       = cnt_popped;
        if (flush_active) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (fire_in) begin
            buf_d = buf_shifted | word_placed;
            cnt_d = cnt_popped + 8'd128;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
